// File: rtl/sfifo_spmem.sv
// sfifo_spmem: synchronous FIFO built on one single-port memory (one access per clock).
// Memory reads have priority over writes. A 2-entry prefetch buffer gives
// first-word-fall-through output.
// Optional feature: define SFIFO_SPMEM_BYPASS_EN to let writes land directly in the
// prefetch buffer while the memory is empty and no read is in flight.
module sfifo_spmem #(
    parameter int unsigned BW     = 48,
    parameter int unsigned LGFLEN = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    output logic              o_wr_ready,
    input  logic [BW-1:0]     i_data,
    input  logic              i_rd,
    output logic              o_rd_valid,
    output logic [BW-1:0]     o_data,
    output logic [LGFLEN+1:0] o_fill,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned     Depth    = 2 ** LGFLEN;
    localparam logic [LGFLEN:0] DepthCnt = (LGFLEN + 1)'(Depth);

    // Storage and the registered read port
    logic [BW-1:0] mem [Depth];
    logic [BW-1:0] rd_data_q;

    // Memory bookkeeping
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   mem_count_q, mem_count_d;
    logic              inflight_q, inflight_d;

    // Prefetch buffer; entry 0 is the head of the FIFO
    logic [1:0]        pf_count_q, pf_count_d;
    logic [BW-1:0]     pf0_q, pf0_d;
    logic [BW-1:0]     pf1_q, pf1_d;

    // Per-cycle control
    logic              pop;
    logic [2:0]        slots;
    logic              mem_has_data;
    logic              read_issue;
    logic              wr_accept;
    logic              bypass;
    logic              mem_we;
    logic              pf_load;
    logic [BW-1:0]     load_data;

    // Arbitration: read issue, write acceptance and bypass decision
    always_comb begin
        pop          = i_rd && o_rd_valid;
        // Prefetch slots that stay claimed after this cycle's pop, including the in-flight word
        slots        = {1'b0, pf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        mem_has_data = (mem_count_q != '0);
        read_issue   = mem_has_data && (slots < 3'd2);
        o_full       = (mem_count_q == DepthCnt);
        o_wr_ready   = !read_issue && !o_full;
        wr_accept    = i_wr && o_wr_ready;
`ifdef SFIFO_SPMEM_BYPASS_EN
        // Only safe when nothing older sits in memory or in the read pipeline
        bypass       = wr_accept && !mem_has_data && !inflight_q && (slots < 3'd2);
`else
        bypass       = 1'b0;
`endif
        mem_we       = wr_accept && !bypass;
    end

    // Pointer, count and in-flight next state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_count_d = mem_count_q;
        inflight_d  = read_issue;
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (read_issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Read and write never happen together: a write is only accepted with no read issued
        if (mem_we) begin
            mem_count_d = mem_count_q + 1'b1;
        end else if (read_issue) begin
            mem_count_d = mem_count_q - 1'b1;
        end
    end

    // Prefetch next state: shift on pop, then place any arriving word in the first free slot
    always_comb begin
        pf_count_d = pf_count_q;
        pf0_d      = pf0_q;
        pf1_d      = pf1_q;
        pf_load    = inflight_q || bypass;
        load_data  = inflight_q ? rd_data_q : i_data;
        if (pop) begin
            pf0_d      = pf1_q;
            pf_count_d = pf_count_q - 1'b1;
        end
        if (pf_load) begin
            if (pf_count_d == 2'd0) begin
                pf0_d = load_data;
            end else begin
                pf1_d = load_data;
            end
            pf_count_d = pf_count_d + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
            pf_count_q  <= 2'd0;
            pf0_q       <= '0;
            pf1_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            inflight_q  <= inflight_d;
            pf_count_q  <= pf_count_d;
            pf0_q       <= pf0_d;
            pf1_q       <= pf1_d;
        end
    end

    // Single-port memory: synchronous write, registered read; contents survive reset
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_reset) begin
            mem[wr_ptr_q] <= i_data;
        end
        if (read_issue) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // Status outputs
    always_comb begin
        o_rd_valid = (pf_count_q != 2'd0);
        o_data     = pf0_q;
        o_fill     = (LGFLEN + 2)'(mem_count_q) + (LGFLEN + 2)'(inflight_q)
                   + (LGFLEN + 2)'(pf_count_q);
        o_empty    = (o_fill == '0);
    end

endmodule

// File: tb/tb_sfifo_spmem.sv
// tb_sfifo_spmem: scoreboard bench for sfifo_spmem (LGFLEN=4).
module tb_sfifo_spmem;

    localparam int unsigned BW     = 48;
    localparam int unsigned LGFLEN = 4;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_wr = 1'b0;
    logic              o_wr_ready;
    logic [BW-1:0]     i_data = '0;
    logic              i_rd = 1'b0;
    logic              o_rd_valid;
    logic [BW-1:0]     o_data;
    logic [LGFLEN+1:0] o_fill;
    logic              o_full;
    logic              o_empty;

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] exp_q[$];

    sfifo_spmem #(
        .BW    (BW),
        .LGFLEN(LGFLEN)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr      (i_wr),
        .o_wr_ready(o_wr_ready),
        .i_data    (i_data),
        .i_rd      (i_rd),
        .o_rd_valid(o_rd_valid),
        .o_data    (o_data),
        .o_fill    (o_fill),
        .o_full    (o_full),
        .o_empty   (o_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, sample at negedge against the scoreboard, commit at posedge
    task automatic step(input logic wr, input logic [BW-1:0] d, input logic rd,
                        output logic acc);
        i_wr   = wr;
        i_data = d;
        i_rd   = rd;
        @(negedge i_clk);
        check("fill", 64'(o_fill), 64'(exp_q.size()));
        check("empty", 64'(o_empty), 64'(exp_q.size() == 0));
        acc = wr && o_wr_ready;
        if (rd && o_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop", 64'(1), 64'(0));
            end else begin
                check("data", 64'(o_data), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
        if (acc) exp_q.push_back(d);
        @(posedge i_clk);
        #1;
        i_wr = 1'b0;
        i_rd = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_wr    = 1'b0;
        i_rd    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        exp_q.delete();
    endtask

    // Hold a write until it is accepted, bounded
    task automatic push_word(input logic [BW-1:0] d, input logic rd);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            step(1'b1, d, rd, acc);
            n++;
        end
        if (!acc) check("push_timeout", 64'(0), 64'(1));
    endtask

    // Pop until the scoreboard is empty, bounded
    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step(1'b0, '0, 1'b1, acc);
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic acc;
        int   accepted;
        int   stalls;
        int   n;
        int   v;

        // 1: reset state
        do_reset();
        repeat (5) step(1'b0, '0, 1'b0, acc);
        check("rst_empty", 64'(o_empty), 64'(1));
        check("rst_fill", 64'(o_fill), 64'(0));
        check("rst_valid", 64'(o_rd_valid), 64'(0));
        check("rst_wr_ready", 64'(o_wr_ready), 64'(1));
        check("rst_data", 64'(o_data), 64'(0));

        // 2: single write latency
        step(1'b1, 48'hA5, 1'b0, acc);
        check("lat_acc", 64'(acc), 64'(1));
`ifdef SFIFO_SPMEM_BYPASS_EN
        check("lat_valid_e0", 64'(o_rd_valid), 64'(1));
`else
        check("lat_valid_e0", 64'(o_rd_valid), 64'(0));
        step(1'b0, '0, 1'b0, acc);
        check("lat_valid_e1", 64'(o_rd_valid), 64'(0));
        step(1'b0, '0, 1'b0, acc);
        check("lat_valid_e2", 64'(o_rd_valid), 64'(1));
`endif
        check("lat_data", 64'(o_data), 64'(48'hA5));
        check("lat_fill", 64'(o_fill), 64'(1));
        drain();

        // 3: fill to capacity, then drain in order
        for (int i = 0; i < 18; i++) push_word(BW'(i), 1'b0);
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 48'hDEAD, 1'b0, acc);
            if (acc) accepted++;
        end
        check("full_extra_acc", 64'(accepted), 64'(0));
        check("full_flag", 64'(o_full), 64'(1));
        check("full_wr_ready", 64'(o_wr_ready), 64'(0));
        check("full_fill", 64'(o_fill), 64'(18));
        drain();
        step(1'b0, '0, 1'b0, acc);
        check("full_drained_empty", 64'(o_empty), 64'(1));

        // 4: full-rate write + pop, 200 words
        v      = 0;
        stalls = 0;
        n      = 0;
        while ((v < 200 || exp_q.size() != 0) && n < 2000) begin
            if (v < 200) begin
                step(1'b1, 48'h1000_0000_0000 | BW'(v), 1'b1, acc);
                if (acc) v++;
                else stalls++;
            end else begin
                step(1'b0, '0, 1'b1, acc);
            end
            n++;
        end
        check("stream_count", 64'(v), 64'(200));
        check("stream_left", 64'(exp_q.size()), 64'(0));
`ifdef SFIFO_SPMEM_BYPASS_EN
        check("stream_stalls", 64'(stalls), 64'(0));
`endif

        // 5: pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) push_word(48'h2000_0000_0000 | BW'(r * 16 + i), 1'b0);
            check("wrap_fill", 64'(o_fill), 64'(16));
            drain();
        end

        // 6: reset with stored data and a read in flight
        for (int i = 0; i < 10; i++) push_word(48'h3000_0000_0000 | BW'(i), 1'b0);
        step(1'b0, '0, 1'b1, acc);
        do_reset();
        check("mid_rst_fill", 64'(o_fill), 64'(0));
        check("mid_rst_valid", 64'(o_rd_valid), 64'(0));
        push_word(48'h3C, 1'b0);
        n = 0;
        while (!o_rd_valid && n < 10) begin
            step(1'b0, '0, 1'b0, acc);
            n++;
        end
        check("mid_rst_valid_after", 64'(o_rd_valid), 64'(1));
        check("mid_rst_head", 64'(o_data), 64'(48'h3C));
        drain();
        step(1'b0, '0, 1'b0, acc);
        check("mid_rst_end_empty", 64'(o_empty), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
